// File: rtl/rec_meas_if.sv
// -----------------------------------------------------------------------------
// rec_meas_if
// Purpose : bundles the sample stream into rec_meas and the measurement
//           results coming back out of it.
// Signals :
//   sample_valid  1      sample qualifier
//   sample        8      signed sample
//   meas_valid    1      one-cycle pulse, new measurement on the result bus
//   period        CNT_W  samples per cycle, rising edge to rising edge
//   high_len      CNT_W  samples at high level within that cycle
//   duty          8      floor(high_len*256/period)
//   locked        1      at least one measurement since reset/timeout
//   timeout       1      one-cycle pulse, counter saturated without a rise
//   overrun       1      one-cycle pulse, rise dropped while divider busy
//   amp_hi/amp_lo 8      signed peak of last high / low phase
//   dbg_state     2      measurement FSM state (0 SEEK, 1 HIGH, 2 LOW)
// Modports: master = sample source / result consumer, slave = rec_meas.
// Handshake: there is no back-pressure. A sample is consumed on every rising
// clock edge where sample_valid is 1; meas_valid qualifies the result bus for
// exactly one cycle and the result fields hold their value until the next one.
// -----------------------------------------------------------------------------
interface rec_meas_if #(
  parameter int CNT_W = 16
);
  logic                    sample_valid;
  logic signed [7:0]       sample;
  logic                    meas_valid;
  logic [CNT_W-1:0]        period;
  logic [CNT_W-1:0]        high_len;
  logic [7:0]              duty;
  logic                    locked;
  logic                    timeout;
  logic                    overrun;
  logic signed [7:0]       amp_hi;
  logic signed [7:0]       amp_lo;
  logic [1:0]              dbg_state;

  modport master (
    output sample_valid, sample,
    input  meas_valid, period, high_len, duty, locked, timeout, overrun,
    input  amp_hi, amp_lo, dbg_state
  );

  modport slave (
    input  sample_valid, sample,
    output meas_valid, period, high_len, duty, locked, timeout, overrun,
    output amp_hi, amp_lo, dbg_state
  );
endinterface

// File: rtl/rec_meas.sv
// -----------------------------------------------------------------------------
// rec_meas
// Purpose : rectangle-wave analyser. Slices the signed sample stream with
//           hysteresis and measures, per cycle (rise to rise), the period, the
//           high length and the duty scaled to 0..255.
// Ports   :
//   clk     in  clock, everything on posedge
//   rst     in  synchronous, active-high reset
//   io_bus  rec_meas_if.slave (sample stream in, measurement results out)
// Parameters:
//   CNT_W   width of the period / high-length counters (samples)
//   HYST    slicer threshold 0..127: s > +HYST is high, s < -HYST is low,
//           anything in between holds the previous level
// Build option:
//   REC_MEAS_AMP_EN  when defined, amp_hi/amp_lo report the signed max of the
//                    last high phase and min of the last low phase; otherwise
//                    they are tied to zero and no tracker is built.
// -----------------------------------------------------------------------------
module rec_meas #(
  parameter int CNT_W = 16,
  parameter int HYST  = 8
) (
  input  logic       clk,
  input  logic       rst,
  rec_meas_if.slave  io_bus
);

  typedef enum logic [1:0] {
    ST_SEEK = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic signed [7:0] THR_HI  = 8'(HYST);
  localparam logic signed [7:0] THR_LO  = -THR_HI;
  localparam logic [3:0]        DIV_STEPS = 4'd8;

  // ---------------------------------------------------------------------------
  // Slicer
  // ---------------------------------------------------------------------------
  logic signed [7:0] w_smp;
  logic              w_valid;
  logic              w_dec_hi;
  logic              w_dec_lo;
  logic              w_rise;
  logic              w_fall;
  logic              r_lvl;
  logic              r_lvl_known;

  assign w_smp    = io_bus.sample;
  assign w_valid  = io_bus.sample_valid;
  assign w_dec_hi = w_valid && (w_smp > THR_HI);
  assign w_dec_lo = w_valid && (w_smp < THR_LO);
  // The first decisive sample only establishes the level; edges need a known level.
  assign w_rise   = r_lvl_known && !r_lvl && w_dec_hi;
  assign w_fall   = r_lvl_known &&  r_lvl && w_dec_lo;

  // ---------------------------------------------------------------------------
  // Measurement FSM and counters
  // ---------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt_tot;
  logic [CNT_W-1:0] r_cnt_hi;
  logic [CNT_W-1:0] w_cnt_tot_nxt;
  logic [CNT_W-1:0] w_cnt_hi_nxt;
  logic [CNT_W-1:0] w_tot_inc;
  logic [CNT_W-1:0] w_hi_inc;
  logic             w_count;
  logic             w_hi_step;
  logic             w_timeout;
  logic             w_meas_start;
  logic             w_overrun;
  logic             w_div_busy;
  logic             w_div_done;

  assign w_tot_inc = r_cnt_tot + CNT_ONE;
  assign w_hi_inc  = r_cnt_hi + CNT_ONE;
  // Every valid sample outside SEEK advances the total count; the fall sample
  // already belongs to the low phase, so it does not advance the high count.
  assign w_count   = w_valid && (r_state != ST_SEEK);
  assign w_hi_step = w_valid && (r_state == ST_HIGH) && !w_fall;
  // Evaluated on the incremented value so a rise on the saturating sample
  // still loses to the timeout.
  assign w_timeout = (w_count && (w_tot_inc == CNT_MAX)) ||
                     (w_hi_step && (w_hi_inc == CNT_MAX));

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_tot_nxt = r_cnt_tot;
    w_cnt_hi_nxt  = r_cnt_hi;
    w_meas_start  = 1'b0;
    w_overrun     = 1'b0;
    case (r_state)
      ST_SEEK: begin
        // First rise only starts counting; nothing to report yet.
        if (w_rise) begin
          w_state_nxt   = ST_HIGH;
          w_cnt_tot_nxt = CNT_ONE;
          w_cnt_hi_nxt  = CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (w_count) begin
          w_cnt_tot_nxt = w_tot_inc;
          if (w_fall) begin
            w_state_nxt = ST_LOW;
          end else begin
            w_cnt_hi_nxt = w_hi_inc;
          end
        end
      end
      ST_LOW: begin
        if (w_count) begin
          if (w_rise) begin
            w_state_nxt   = ST_HIGH;
            w_cnt_tot_nxt = CNT_ONE;
            w_cnt_hi_nxt  = CNT_ONE;
            if (w_div_busy) begin
              w_overrun = 1'b1;
            end else begin
              w_meas_start = 1'b1;
            end
          end else begin
            w_cnt_tot_nxt = w_tot_inc;
          end
        end
      end
      default: begin
        w_state_nxt   = ST_SEEK;
        w_cnt_tot_nxt = '0;
        w_cnt_hi_nxt  = '0;
      end
    endcase
    if (w_timeout) begin
      w_state_nxt   = ST_SEEK;
      w_cnt_tot_nxt = '0;
      w_cnt_hi_nxt  = '0;
      w_meas_start  = 1'b0;
      w_overrun     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SEEK;
      r_cnt_tot   <= '0;
      r_cnt_hi    <= '0;
      r_lvl       <= 1'b0;
      r_lvl_known <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt_tot <= w_cnt_tot_nxt;
      r_cnt_hi  <= w_cnt_hi_nxt;
      if (w_timeout) begin
        r_lvl       <= 1'b0;
        r_lvl_known <= 1'b0;
      end else if (w_dec_hi || w_dec_lo) begin
        r_lvl       <= w_dec_hi;
        r_lvl_known <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Restoring divider: duty = floor(hi*256/tot), one quotient bit per clock.
  // Started at the rise edge t, iterates on t+1..t+8, results load at t+9.
  // Because hi < tot the running remainder always stays below the divisor.
  // ---------------------------------------------------------------------------
  logic             r_div_act;
  logic [3:0]       r_div_cnt;
  logic [CNT_W-1:0] r_lat_tot;
  logic [CNT_W-1:0] r_lat_hi;
  logic [CNT_W:0]   r_rem;
  logic [7:0]       r_quo;
  logic [CNT_W:0]   w_rem_sh;
  logic [CNT_W:0]   w_den_x;
  logic             w_ge;

  assign w_div_busy = r_div_act && (r_div_cnt != DIV_STEPS);
  assign w_div_done = r_div_act && (r_div_cnt == DIV_STEPS);
  assign w_rem_sh   = r_rem << 1;
  assign w_den_x    = {1'b0, r_lat_tot};
  assign w_ge       = (w_rem_sh >= w_den_x);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_act <= 1'b0;
      r_div_cnt <= '0;
      r_lat_tot <= '0;
      r_lat_hi  <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
    end else begin
      if (w_div_busy) begin
        r_div_cnt <= r_div_cnt + 4'd1;
        r_rem     <= w_ge ? (w_rem_sh - w_den_x) : w_rem_sh;
        r_quo     <= {r_quo[6:0], w_ge};
      end
      // A start can only coincide with the done cycle, never with a busy step.
      if (w_meas_start) begin
        r_div_act <= 1'b1;
        r_div_cnt <= '0;
        r_lat_tot <= r_cnt_tot;
        r_lat_hi  <= r_cnt_hi;
        r_rem     <= {1'b0, r_cnt_hi};
        r_quo     <= '0;
      end else if (w_div_done) begin
        r_div_act <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------------
  logic             r_meas_valid;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high_len;
  logic [7:0]       r_duty;
  logic             r_locked;
  logic             r_timeout;
  logic             r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meas_valid <= 1'b0;
      r_period     <= '0;
      r_high_len   <= '0;
      r_duty       <= '0;
      r_locked     <= 1'b0;
      r_timeout    <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_meas_valid <= w_div_done;
      r_timeout    <= w_timeout;
      r_overrun    <= w_overrun;
      if (w_div_done) begin
        r_period   <= r_lat_tot;
        r_high_len <= r_lat_hi;
        r_duty     <= r_quo;
        r_locked   <= 1'b1;
      end
      if (w_timeout) begin
        r_locked <= 1'b0;
      end
    end
  end

`ifdef REC_MEAS_AMP_EN
  // ---------------------------------------------------------------------------
  // Amplitude trackers. r_max follows the current high phase and is parked in
  // r_hmax at the fall; r_min follows the current low phase. Both restart from
  // the edge sample. The pair is captured at an accepted rise and published
  // together with the divider result.
  // ---------------------------------------------------------------------------
  logic signed [7:0] r_max;
  logic signed [7:0] r_min;
  logic signed [7:0] r_hmax;
  logic signed [7:0] r_lat_amp_hi;
  logic signed [7:0] r_lat_amp_lo;
  logic signed [7:0] r_amp_hi;
  logic signed [7:0] r_amp_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_max        <= '0;
      r_min        <= '0;
      r_hmax       <= '0;
      r_lat_amp_hi <= '0;
      r_lat_amp_lo <= '0;
      r_amp_hi     <= '0;
      r_amp_lo     <= '0;
    end else begin
      if (w_valid) begin
        case (r_state)
          ST_SEEK: begin
            if (w_rise) begin
              r_max <= w_smp;
            end
          end
          ST_HIGH: begin
            if (w_fall) begin
              r_hmax <= r_max;
              r_min  <= w_smp;
            end else if (w_smp > r_max) begin
              r_max <= w_smp;
            end
          end
          ST_LOW: begin
            if (w_rise) begin
              r_max <= w_smp;
            end else if (w_smp < r_min) begin
              r_min <= w_smp;
            end
          end
          default: begin
            r_max <= r_max;
          end
        endcase
      end
      if (w_meas_start) begin
        r_lat_amp_hi <= r_hmax;
        r_lat_amp_lo <= r_min;
      end
      if (w_div_done) begin
        r_amp_hi <= r_lat_amp_hi;
        r_amp_lo <= r_lat_amp_lo;
      end
    end
  end

  assign io_bus.amp_hi = r_amp_hi;
  assign io_bus.amp_lo = r_amp_lo;
`else
  assign io_bus.amp_hi = 8'sd0;
  assign io_bus.amp_lo = 8'sd0;
`endif

  assign io_bus.meas_valid = r_meas_valid;
  assign io_bus.period     = r_period;
  assign io_bus.high_len   = r_high_len;
  assign io_bus.duty       = r_duty;
  assign io_bus.locked     = r_locked;
  assign io_bus.timeout    = r_timeout;
  assign io_bus.overrun    = r_overrun;
  assign io_bus.dbg_state  = r_state;

endmodule
